ris_frame_buf_ctrl: RTL and testbench

- Ping-pong controller for the 256x32 dual-port frame-buffer BRAM: port A write, port B synchronous read with rd_en hold.
- Accepts RIS element-configuration words from an upstream valid/ready stream and fills them into one half (bank) of the BRAM.
- Plays completed frames out to the RIS element driver over a valid/ready stream.
- The two banks alternate, so the host can load frame N+1 while frame N plays out.

---
 rtl/ris_frame_buf_ctrl.sv | 113 +++++++++++
 tb/tb_ris_frame_buf_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ris_frame_buf_ctrl.sv
// ris_frame_buf_ctrl: ping-pong fill/playout controller for a 256xDATA_W dual-port frame BRAM.
// Optional RIS_AUTO_PLAY_EN: start playout whenever the read bank is full, ignoring play_start.
module ris_frame_buf_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              play_start,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              bram_we,
  output logic [7:0]        bram_waddr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              bram_rd_en,
  output logic [7:0]        bram_raddr,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [1:0]        full,
  output logic              play_busy,
  output logic              start_miss
);
  localparam logic [6:0] LAST = 7'(FRAME_LEN - 1);
  typedef enum logic [1:0] {R_IDLE, R_PLAY, R_DRAIN} r_state_e;
  r_state_e    state_q;
  logic        wr_bank_q, rd_bank_q;
  logic [6:0]  widx_q, ridx_q;
  logic [1:0]  full_q, full_d;
  logic        m_valid_q, m_last_q, start_miss_q;
  logic        accept, wr_done, rd_done, go, miss;
  assign accept  = m_valid_q & m_ready;
  assign wr_done = bram_we & (widx_q == LAST);
  assign rd_done = (state_q == R_DRAIN) & accept;
`ifdef RIS_AUTO_PLAY_EN
  assign go   = (state_q == R_IDLE) & full_q[rd_bank_q];
  assign miss = 1'b0;
`else
  assign go   = (state_q == R_IDLE) & play_start & full_q[rd_bank_q];
  assign miss = play_start & !go;
`endif
  assign s_ready    = !full_q[wr_bank_q];
  assign bram_we    = s_valid & s_ready;
  assign bram_waddr = {wr_bank_q, widx_q};
  assign bram_wdata = s_data;
  // A read is only issued when the output register is free, so bram_rdata holds under backpressure.
  assign bram_rd_en = (state_q == R_PLAY) & (!m_valid_q | m_ready);
  assign bram_raddr = {rd_bank_q, ridx_q};
  assign m_data     = bram_rdata;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign full       = full_q;
  assign play_busy  = state_q != R_IDLE;
  assign start_miss = start_miss_q;
  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= R_IDLE;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      widx_q       <= '0;
      ridx_q       <= '0;
      full_q       <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      start_miss_q <= 1'b0;
    end else if (abort) begin
      state_q      <= R_IDLE;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      widx_q       <= '0;
      ridx_q       <= '0;
      full_q       <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      start_miss_q <= 1'b0;
    end else begin
      full_q       <= full_d;
      start_miss_q <= miss;
      if (bram_we) begin
        widx_q <= wr_done ? 7'd0 : widx_q + 7'd1;
        if (wr_done) wr_bank_q <= !wr_bank_q;
      end
      unique case (state_q)
        R_IDLE: if (go) begin
          state_q <= R_PLAY;
          ridx_q  <= '0;
        end
        R_PLAY: if (bram_rd_en) begin
          m_valid_q <= 1'b1;
          m_last_q  <= ridx_q == LAST;
          ridx_q    <= ridx_q + 7'd1;
          if (ridx_q == LAST) state_q <= R_DRAIN;
        end
        R_DRAIN: if (accept) begin
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
          rd_bank_q <= !rd_bank_q;
          state_q   <= R_IDLE;
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ris_frame_buf_ctrl.sv
// tb_ris_frame_buf_ctrl: scoreboard bench for ris_frame_buf_ctrl with a behavioural BRAM, FRAME_LEN=4.
module tb_ris_frame_buf_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        play_start = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic        bram_we;
  logic [7:0]  bram_waddr;
  logic [31:0] bram_wdata;
  logic        bram_rd_en;
  logic [7:0]  bram_raddr;
  logic [31:0] bram_rdata = '0;
  logic [1:0]  full;
  logic        play_busy;
  logic        start_miss;
  int          total = 0;
  int          bad = 0;
  logic [32:0] exp_q[$];
  logic [31:0] mem[256];
  logic [3:0]  pat = 4'b1001;

  ris_frame_buf_ctrl #(.FRAME_LEN(4), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .play_start(play_start),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
    .bram_rd_en(bram_rd_en), .bram_raddr(bram_raddr), .bram_rdata(bram_rdata),
    .full(full), .play_busy(play_busy), .start_miss(start_miss)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_we) mem[bram_waddr] <= bram_wdata;
    if (bram_rd_en) bram_rdata <= mem[bram_raddr];
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d, input logic [7:0] a, input bit last, input bit push);
    s_valid = 1'b1;
    s_data  = d;
    #2;
    chk("wr_s_ready", s_ready, 1);
    chk("wr_we", bram_we, 1);
    chk("wr_addr", bram_waddr, a);
    if (push) exp_q.push_back({last, d});
    tick();
    s_valid = 1'b0;
  endtask

  task automatic pulse_play();
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    #2;
  endtask

  task automatic drain_to(input int left);
    for (int i = 0; i < 60 && exp_q.size() > left; i++) begin
      tick();
      #2;
    end
    chk("drain_left", exp_q.size(), left);
  endtask

  // Monitor: every presented word must match the head of the queue; popped on accept.
  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %0h expected none", m_data);
      end else begin
        chk("m_data", m_data, exp_q[0][31:0]);
        chk("m_last", m_last, 32'(exp_q[0][32]));
        if (m_ready) void'(exp_q.pop_front());
        else chk("stall_rd_en", bram_rd_en, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", play_busy, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_rd_en", bram_rd_en, 0);
    chk("rst_miss", start_miss, 0);
    rst_n = 1'b1;
    tick();
    #2;
    chk("rst_s_ready", s_ready, 1);
`ifdef RIS_AUTO_PLAY_EN
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) wr(32'hA0 + 32'(i), 8'(i), i == 3, 1);
    for (int i = 0; i < 4; i++) wr(32'hB0 + 32'(i), 8'h80 + 8'(i), i == 3, 1);
    pulse_play();
    tick();
    #2;
    chk("auto_no_miss", start_miss, 0);
    drain_to(0);
    tick();
    #2;
    chk("auto_full", full, 0);
    chk("auto_busy", play_busy, 0);
`else
    // Single frame, full-rate playout.
    for (int i = 0; i < 4; i++) wr(32'h11 * 32'(i + 1), 8'(i), i == 3, 1);
    #2;
    chk("f1_full", full, 2'b01);
    chk("f1_s_ready", s_ready, 1);
    m_ready = 1'b1;
    pulse_play();
    chk("f1_no_miss", start_miss, 0);
    chk("f1_busy", play_busy, 1);
    chk("f1_lat_valid", m_valid, 0);
    chk("f1_rd_en", bram_rd_en, 1);
    chk("f1_raddr", bram_raddr, 8'h00);
    drain_to(0);
    chk("f1_full_clr", full, 0);
    chk("f1_idle", play_busy, 0);
    // Restart from bank 0, fill both banks.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 4; i++) wr(32'h100 + 32'(i), 8'(i), i == 3, 1);
    for (int i = 0; i < 4; i++) wr(32'h200 + 32'(i), 8'h80 + 8'(i), i == 3, 1);
    s_valid = 1'b1;
    s_data  = 32'h99;
    #2;
    chk("both_full", full, 2'b11);
    chk("both_s_ready", s_ready, 0);
    chk("both_we", bram_we, 0);
    pulse_play();
    for (int i = 0; i < 60 && exp_q.size() > 4; i++) begin
      chk("blocked_s_ready", s_ready, 0);
      m_ready = pat[i % 4];
      tick();
      #2;
    end
    chk("bank0_left", exp_q.size(), 4);
    chk("reopen_s_ready", s_ready, 1);
    chk("reopen_we", bram_we, 1);
    chk("reopen_addr", bram_waddr, 8'h00);
    exp_q.push_back({1'b0, 32'h99});
    tick();
    s_valid = 1'b0;
    // Bank 1 playout with a redundant play_start mid-frame.
    m_ready = 1'b1;
    pulse_play();
    tick();
    pulse_play();
    chk("busy_miss", start_miss, 1);
    chk("busy_still", play_busy, 1);
    drain_to(1);
    chk("b1_full", full, 0);
    chk("b1_idle", play_busy, 0);
    pulse_play();
    chk("empty_miss", start_miss, 1);
    chk("empty_busy", play_busy, 0);
    tick();
    #2;
    chk("miss_pulse_end", start_miss, 0);
    // Complete bank 0, leave bank 1 partial, abort mid-playout.
    wr(32'hC1, 8'h01, 0, 1);
    wr(32'hC2, 8'h02, 0, 1);
    wr(32'hC3, 8'h03, 1, 1);
    wr(32'hD1, 8'h80, 0, 0);
    wr(32'hD2, 8'h81, 0, 0);
    #2;
    chk("ab_full", full, 2'b01);
    pulse_play();
    drain_to(2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #2;
    chk("ab_m_valid", m_valid, 0);
    chk("ab_full_clr", full, 0);
    chk("ab_s_ready", s_ready, 1);
    chk("ab_busy", play_busy, 0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) wr(32'hE0 + 32'(i), 8'(i), i == 3, 1);
    pulse_play();
    drain_to(0);
    chk("fresh_full", full, 0);
`endif
    tick();
    chk("final_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
